// File: rtl/debug_port_tx.sv
// UART transmitter that snapshots debug_port_vector on trigger and sends it as a framed byte stream.
// Define DEBUG_TX_CHECKSUM_EN to append an XOR checksum byte over the payload.
module debug_port_tx #(
    parameter int          DEBUG_BYTES  = 30,
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [8:DEBUG_BYTES*8-1]   debug_port_vector,
    input  logic                       trigger,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       uart_tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = $clog2(DEBUG_BYTES + 1);
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam int NUM_BYTES = DEBUG_BYTES + 1;
`else
    localparam int NUM_BYTES = DEBUG_BYTES;
`endif
    localparam int NUM_SLOTS = 1 << BYTE_W;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                     state, state_nx;
    logic [BAUD_W-1:0]          baud, baud_nx;
    logic [2:0]                 bit_idx, bit_nx;
    logic [BYTE_W-1:0]          byte_idx, byte_nx;
    logic                       done_nx;
    logic                       capture;
    logic                       bit_end;
    logic [8:DEBUG_BYTES*8-1]   shadow;
    logic [7:0]                 slot [NUM_SLOTS];

    // Frame byte table: header, payload bytes (shadow index k*8 is the MSB), optional checksum.
    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot[k] = '0;
        end
        slot[0] = SYNC_BYTE;
        for (int k = 1; k < DEBUG_BYTES; k++) begin
            for (int j = 0; j < 8; j++) begin
                slot[k][7-j] = shadow[k*8+j];
            end
        end
`ifdef DEBUG_TX_CHECKSUM_EN
        for (int k = 1; k < DEBUG_BYTES; k++) begin
            slot[DEBUG_BYTES] = slot[DEBUG_BYTES] ^ slot[k];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            frame_done <= 1'b0;
            shadow     <= '0;
        end else begin
            state      <= state_nx;
            baud       <= baud_nx;
            bit_idx    <= bit_nx;
            byte_idx   <= byte_nx;
            frame_done <= done_nx;
            if (capture) begin
                shadow <= debug_port_vector;
            end
        end
    end

    assign bit_end = (baud == BAUD_LAST);

    always_comb begin
        state_nx = state;
        baud_nx  = baud;
        bit_nx   = bit_idx;
        byte_nx  = byte_idx;
        done_nx  = 1'b0;
        capture  = 1'b0;
        uart_tx  = 1'b1;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (trigger) begin
                    capture  = 1'b1;
                    byte_nx  = '0;
                    bit_nx   = '0;
                    baud_nx  = '0;
                    state_nx = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (bit_end) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    state_nx = DATA;
                end else begin
                    baud_nx = baud + 1'b1;
                end
            end
            DATA: begin
                uart_tx = slot[byte_idx][bit_idx];
                if (bit_end) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bit_nx = bit_idx + 1'b1;
                    end
                end else begin
                    baud_nx = baud + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_nx = '0;
                    if (byte_idx == BYTE_LAST) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        byte_nx  = byte_idx + 1'b1;
                        state_nx = START;
                    end
                end else begin
                    baud_nx = baud + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_debug_port_tx.sv
// Bench for debug_port_tx: queue-based line model compared every cycle, plus literal frame decodes.
module tb_debug_port_tx;

    localparam int CPB = 4;
    localparam int DB  = 4;
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam int NB = DB + 1;
    localparam int FRAME_LIT = 200;
`else
    localparam int NB = DB;
    localparam int FRAME_LIT = 160;
`endif
    localparam int L = NB * 10 * CPB;

    logic             clk = 1'b0;
    logic             nreset;
    logic [8:DB*8-1]  vec;
    logic             trigger;
    logic             busy, frame_done, uart_tx;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    bit   q[$];
    logic exp_done = 1'b0;

    bit   rec[$];
    int   busy_cnt = 0;
    int   done_cnt = 0;

    debug_port_tx #(.DEBUG_BYTES(DB), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .nreset(nreset), .debug_port_vector(vec), .trigger(trigger),
        .busy(busy), .frame_done(frame_done), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: a frame is just a list of per-cycle line levels built from the snapshot.
    task automatic build_frame(input logic [8:DB*8-1] snap);
        logic [7:0] val, csum;
        csum = 8'h00;
        for (int b = 1; b < DB; b++) csum ^= snap[b*8 +: 8];
        for (int b = 0; b < NB; b++) begin
            if (b == 0)       val = 8'hA5;
            else if (b < DB)  val = snap[b*8 +: 8];
            else              val = csum;
            repeat (CPB) q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (CPB) q.push_back(val[i]);
            repeat (CPB) q.push_back(1'b1);
        end
    endtask

    always @(posedge clk) begin
        if (nreset === 1'b1) begin
            q.delete();
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (q.size() > 0) begin
                void'(q.pop_front());
                if (q.size() == 0) exp_done = 1'b1;
            end else if (trigger === 1'b1) begin
                build_frame(vec);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("tx",   uart_tx,    (q.size() > 0) ? q[0] : 1'b1);
            chk("busy", busy,       q.size() > 0);
            chk("done", frame_done, exp_done);
        end
    end

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            rec.push_back(uart_tx);
            busy_cnt++;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic clear_rec();
        rec.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic send(input logic [8:DB*8-1] v);
        vec = v;
        trigger = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                @(negedge clk);
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL wait_end: busy still %0b after 2000 cycles, expected 0", busy);
    endtask

    // Decodes frame f of the recorded busy-time line samples at mid-bit.
    task automatic check_frame(input string name, input int f, input logic [39:0] exp_bytes);
        int base;
        logic [7:0] val;
        for (int b = 0; b < NB; b++) begin
            base = f * L + b * 10 * CPB;
            if (rec.size() < base + 10 * CPB) begin
                chk($sformatf("%s_len", name), rec.size(), base + 10 * CPB);
                return;
            end
            chk($sformatf("%s_b%0d_start", name, b), rec[base + CPB/2], 0);
            for (int i = 0; i < 8; i++) val[i] = rec[base + (1 + i) * CPB + CPB/2];
            chk($sformatf("%s_b%0d_stop", name, b), rec[base + 9*CPB + CPB/2], 1);
            chk($sformatf("%s_b%0d", name, b), val, exp_bytes[39 - 8*b -: 8]);
        end
    endtask

    initial begin
        nreset  = 1'b1;
        trigger = 1'b0;
        vec     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        chk("rst_tx", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        nreset = 1'b0;
        clear_rec();
        repeat (20) @(negedge clk);
        chk("idle_tx", uart_tx, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done_cnt", done_cnt, 0);

        // single frame
        clear_rec();
        send(24'h0180FF);
        wait_end();
        chk("single_busy_cycles", busy_cnt, FRAME_LIT);
        chk("single_done_cnt", done_cnt, 1);
        check_frame("single", 0, 40'hA5_01_80_FF_7E);

        // snapshot stability and back-to-back frame
        clear_rec();
        send(24'h0180FF);
        vec = 24'hAABBCC;
        repeat (L) @(negedge clk);
        trigger = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trigger = 1'b0;
        wait_end();
        chk("b2b_busy_cycles", busy_cnt, 2 * FRAME_LIT);
        chk("b2b_done_cnt", done_cnt, 2);
        check_frame("snap", 0, 40'hA5_01_80_FF_7E);
        check_frame("b2b", 1, 40'hA5_AA_BB_CC_DD);

        // trigger during frame is ignored
        clear_rec();
        send(24'h0180FF);
        repeat (50) @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_end();
        chk("ign_busy_cycles", busy_cnt, FRAME_LIT);
        chk("ign_done_cnt", done_cnt, 1);
        check_frame("ign", 0, 40'hA5_01_80_FF_7E);

        // reset mid-frame
        clear_rec();
        send(24'h0180FF);
        repeat (70) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        chk("midrst_tx", uart_tx, 1);
        chk("midrst_busy", busy, 0);
        nreset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_done_cnt", done_cnt, 0);
        clear_rec();
        send(24'h5A3C0F);
        wait_end();
        chk("post_busy_cycles", busy_cnt, FRAME_LIT);
        chk("post_done_cnt", done_cnt, 1);
        check_frame("post", 0, 40'hA5_5A_3C_0F_69);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_port_tx.md
# debug_port_tx

Serial transmitter for the CPU debug port. It captures a snapshot of the CPU's `debug_port_vector` on request and shifts it out on a single UART line as a framed byte stream, so the host can observe PC, stage ready flags, register-file traffic and CPSR. It sits directly downstream of the CPU top level, consuming its debug vector, and drives the board's TX pin.

## Interface
- `DEBUG_BYTES`, default `30`: frame size in bytes. Byte 0 is the sync header and bytes `1..DEBUG_BYTES-1` are payload.
- `CLKS_PER_BIT`, default `104`: clock cycles per UART bit. Must be at least 2.
- `SYNC_BYTE`, default `8'hA5`: header value sent as byte 0.

Ports (name, direction, width, meaning):
- `clk` input 1: clock.
- `nreset` input 1: reset, synchronous, active-high. While `nreset`=1 the block is held in reset.
- `debug_port_vector` input `[8:DEBUG_BYTES*8-1]`: payload. Byte k occupies bits `[k*8 : k*8+7]`, and index `k*8` is that byte's MSB.
- `trigger` input 1: request one frame. Sampled only in IDLE.
- `busy` output 1: high while a frame is in progress.
- `frame_done` output 1: one-cycle pulse when a frame completes.
- `uart_tx` output 1: serial line, idle high.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE:** `uart_tx`=1 and `busy`=0.
  - On `trigger`=1, latch `debug_port_vector` into a shadow register.
  - Clear the byte index to 0 and go to START.
- **START:** drive 0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index at 0.
- **DATA:** drive the current byte LSB-first, each bit for `CLKS_PER_BIT` cycles.
  - Bit i of byte k is shadow bit `k*8+7-i`.
  - Byte 0 uses `SYNC_BYTE` instead of the shadow.
  - After bit 7, go to STOP.
- **STOP:** drive 1 for `CLKS_PER_BIT` cycles. Then:
  - if more bytes remain, increment the byte index and go to START;
  - otherwise go to IDLE and pulse `frame_done`.
- The baud counter counts 0 to `CLKS_PER_BIT-1`. It wraps to 0 at each bit boundary and is cleared on IDLE→START.
- The bit index is 3 bits and the byte index is `$clog2(DEBUG_BYTES+1)` bits. Neither counter wraps within a frame.
- The shadow register is fixed for the whole frame. Changes on `debug_port_vector` after capture have no effect until the next capture.

## Timing
- **Reset values:** `uart_tx`=1, `busy`=0, `frame_done`=0, state IDLE, all counters 0.
- **Frame start:** a trigger sampled at edge N gives `busy`=1 and `uart_tx`=0 (start bit) from edge N onward.
- **Frame length:** exactly `NB*10*CLKS_PER_BIT` cycles, where `NB`=`DEBUG_BYTES` (plus 1 with checksum). The frame has no gaps between bytes.
- **Frame end:**
  - `frame_done` is high for exactly the first cycle back in IDLE, and `busy` is 0 in that same cycle.
  - A `trigger` in that cycle is accepted, giving back-to-back frames.
- **Trigger during frame:** `trigger` while `busy`=1 is ignored and not queued.
- **Reset mid-frame:** on the next edge, `uart_tx` is 1 and `busy` is 0. The frame is abandoned and no `frame_done` pulse occurs.
- **Held trigger:** holding `trigger` high produces continuous frames, each with a fresh snapshot.

## Configuration
- **`DEBUG_TX_CHECKSUM_EN` defined:**
  - After the last payload byte, send one extra byte equal to the XOR of payload bytes `1..DEBUG_BYTES-1`. `SYNC_BYTE` is excluded.
  - The checksum is computed from the shadow register.
  - `frame_done` follows the checksum byte's stop bit.
- **Not defined:** the frame ends after byte `DEBUG_BYTES-1` and no checksum logic is present.

## Test plan
The bench uses `CLKS_PER_BIT`=4 and `DEBUG_BYTES`=4.
- **Reset:** hold `nreset`=1 for 3 cycles, then release with `trigger`=0 for 20 cycles → `uart_tx`=1, `busy`=0, and `frame_done` never pulses.
- **Single frame:** payload bytes `01 80 FF`, one-cycle trigger → the line decodes as `A5 01 80 FF`. Every start bit is 0 and every stop bit is 1. `busy` is high for 160 cycles (200 with checksum). `frame_done` pulses once.
- **Checksum:** same stimulus with `DEBUG_TX_CHECKSUM_EN` defined → fifth byte is `0x7E` and the frame is 200 cycles.
- **Snapshot stability:** change `debug_port_vector` to `AA BB CC` one cycle after trigger → the transmitted payload is still `01 80 FF`. A second trigger on the `frame_done` cycle sends `AA BB CC` with no idle gap.
- **Ignored trigger:** pulse `trigger` at cycle 50 of a frame → no effect on the bitstream, and the frame ends at the expected cycle.
- **Reset mid-frame:** assert `nreset` at cycle 70 → `uart_tx`=1 and `busy`=0 on the next edge, no `frame_done`. After release, a new trigger sends a complete, correct frame.
